mem_port_arbiter: RTL and testbench

// - Shares the single data port (req/resp) of the unified memory model between instruction fetch (IFU) and load/store (LSU).
// - Sits between the core's IFU/LSU and the memory; allows one outstanding transaction.
// - Routes each response to its issuer and recovers from lost responses via a timeout.

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares the memory data port between IFU and LSU with one outstanding transaction and a timeout.
// Optional round-robin arbitration when MEM_ARB_RR_EN is defined; fixed LSU > IFU priority otherwise.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 64,
    parameter logic [2:0]  IFU_OP  = 3'd3,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                io_ifu_req_valid,
    output logic                io_ifu_req_ready,
    input  logic [ADDR_W-1:0]   io_ifu_req_addr,
    output logic                io_ifu_resp_valid,
    output logic [DATA_W-1:0]   io_ifu_resp_rdata,

    input  logic                io_lsu_req_valid,
    output logic                io_lsu_req_ready,
    input  logic [ADDR_W-1:0]   io_lsu_req_addr,
    input  logic [DATA_W/8-1:0] io_lsu_req_mask,
    input  logic [2:0]          io_lsu_req_op,
    input  logic [DATA_W-1:0]   io_lsu_req_wdata,
    input  logic                io_lsu_req_wen,
    output logic                io_lsu_resp_valid,
    output logic [DATA_W-1:0]   io_lsu_resp_rdata,

    output logic                io_mem_req_valid,
    input  logic                io_mem_req_ready,
    output logic [ADDR_W-1:0]   io_mem_req_addr,
    output logic [DATA_W/8-1:0] io_mem_req_mask,
    output logic [2:0]          io_mem_req_op,
    output logic [DATA_W-1:0]   io_mem_req_wdata,
    output logic                io_mem_req_memen,
    output logic                io_mem_req_wen,
    input  logic                io_mem_resp_valid,
    input  logic [DATA_W-1:0]   io_mem_resp_rdata,

    output logic                io_err_timeout
);

    localparam int unsigned TIMER_W = 8;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic { ST_IDLE, ST_BUSY } state_e;
    typedef enum logic { GNT_IFU, GNT_LSU } gnt_e;

    state_e               state_q, state_d;
    gnt_e                 owner_q, owner_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    gnt_e                 winner;
    logic                 live;
    logic                 fire;

`ifdef MEM_ARB_RR_EN
    gnt_e                 last_grant_q, last_grant_d;

    // Alternate on contention; a lone requester always wins.
    always_comb begin
        winner = GNT_IFU;
        if (io_lsu_req_valid && io_ifu_req_valid) begin
            winner = (last_grant_q == GNT_LSU) ? GNT_IFU : GNT_LSU;
        end else if (io_lsu_req_valid) begin
            winner = GNT_LSU;
        end
    end
`else
    always_comb begin
        winner = io_lsu_req_valid ? GNT_LSU : GNT_IFU;
    end
`endif

    // Request fields follow the current winner; only qualified by valid.
    always_comb begin
        io_mem_req_memen = 1'b1;
        if (winner == GNT_LSU) begin
            io_mem_req_addr  = io_lsu_req_addr;
            io_mem_req_mask  = io_lsu_req_mask;
            io_mem_req_op    = io_lsu_req_op;
            io_mem_req_wdata = io_lsu_req_wdata;
            io_mem_req_wen   = io_lsu_req_wen;
        end else begin
            io_mem_req_addr  = io_ifu_req_addr;
            io_mem_req_mask  = '1;
            io_mem_req_op    = IFU_OP;
            io_mem_req_wdata = '0;
            io_mem_req_wen   = 1'b0;
        end
    end

    assign io_ifu_resp_rdata = io_mem_resp_rdata;
    assign io_lsu_resp_rdata = io_mem_resp_rdata;

    // Handshakes are suppressed while reset is held so nothing is accepted or delivered.
    always_comb begin
        state_d           = state_q;
        owner_d           = owner_q;
        timer_d           = timer_q;
`ifdef MEM_ARB_RR_EN
        last_grant_d      = last_grant_q;
`endif
        live              = !reset;
        fire              = 1'b0;
        io_mem_req_valid  = 1'b0;
        io_ifu_req_ready  = 1'b0;
        io_lsu_req_ready  = 1'b0;
        io_ifu_resp_valid = 1'b0;
        io_lsu_resp_valid = 1'b0;
        io_err_timeout    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                io_mem_req_valid = live && (io_ifu_req_valid || io_lsu_req_valid);
                io_ifu_req_ready = live && io_mem_req_ready && (winner == GNT_IFU);
                io_lsu_req_ready = live && io_mem_req_ready && (winner == GNT_LSU);
                fire             = io_mem_req_valid && io_mem_req_ready;
                if (fire) begin
                    state_d = ST_BUSY;
                    owner_d = winner;
                    timer_d = '0;
`ifdef MEM_ARB_RR_EN
                    last_grant_d = winner;
`endif
                end
            end
            ST_BUSY: begin
                if (io_mem_resp_valid) begin
                    io_ifu_resp_valid = live && (owner_q == GNT_IFU);
                    io_lsu_resp_valid = live && (owner_q == GNT_LSU);
                    state_d           = ST_IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    io_err_timeout = live;
                    state_d        = ST_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= GNT_IFU;
            timer_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= GNT_IFU;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            timer_q <= timer_d;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected requests/responses are queued as stimulus is driven
// and popped by a negedge monitor; directed sequences cover priority, timeout, stall and reset abort.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned MASK_W  = DATA_W / 8;
    localparam int unsigned TIMEOUT = 4;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [ADDR_W-1:0] ifu_req_addr;
    logic [DATA_W-1:0] ifu_resp_rdata;
    logic              lsu_req_valid, lsu_req_ready, lsu_resp_valid, lsu_req_wen;
    logic [ADDR_W-1:0] lsu_req_addr;
    logic [MASK_W-1:0] lsu_req_mask;
    logic [2:0]        lsu_req_op;
    logic [DATA_W-1:0] lsu_req_wdata, lsu_resp_rdata;
    logic              mem_req_valid, mem_req_ready, mem_req_memen, mem_req_wen;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [MASK_W-1:0] mem_req_mask;
    logic [2:0]        mem_req_op;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_rdata;
    logic              err_timeout;

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .IFU_OP (3'd3),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .io_ifu_req_valid (ifu_req_valid),
        .io_ifu_req_ready (ifu_req_ready),
        .io_ifu_req_addr  (ifu_req_addr),
        .io_ifu_resp_valid(ifu_resp_valid),
        .io_ifu_resp_rdata(ifu_resp_rdata),
        .io_lsu_req_valid (lsu_req_valid),
        .io_lsu_req_ready (lsu_req_ready),
        .io_lsu_req_addr  (lsu_req_addr),
        .io_lsu_req_mask  (lsu_req_mask),
        .io_lsu_req_op    (lsu_req_op),
        .io_lsu_req_wdata (lsu_req_wdata),
        .io_lsu_req_wen   (lsu_req_wen),
        .io_lsu_resp_valid(lsu_resp_valid),
        .io_lsu_resp_rdata(lsu_resp_rdata),
        .io_mem_req_valid (mem_req_valid),
        .io_mem_req_ready (mem_req_ready),
        .io_mem_req_addr  (mem_req_addr),
        .io_mem_req_mask  (mem_req_mask),
        .io_mem_req_op    (mem_req_op),
        .io_mem_req_wdata (mem_req_wdata),
        .io_mem_req_memen (mem_req_memen),
        .io_mem_req_wen   (mem_req_wen),
        .io_mem_resp_valid(mem_resp_valid),
        .io_mem_resp_rdata(mem_resp_rdata),
        .io_err_timeout   (err_timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit                lsu;
        logic [ADDR_W-1:0] addr;
        logic [MASK_W-1:0] mask;
        logic [2:0]        op;
        logic [DATA_W-1:0] wdata;
        bit                wen;
    } req_t;

    typedef struct {
        bit                lsu;
        logic [DATA_W-1:0] data;
    } resp_t;

    req_t  exp_req[$];
    resp_t exp_resp[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    err_total = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Monitor: every accepted memory request and every requester response is matched to the queues.
    always @(negedge clock) begin
        if (!reset) begin
            if (err_timeout) err_total++;
            if (mem_req_valid && mem_req_ready) begin
                if (exp_req.size() == 0) begin
                    check_eq("req_unexpected", 64'(mem_req_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    req_t e;
                    e = exp_req.pop_front();
                    check_eq("req_grant", {62'd0, lsu_req_ready, ifu_req_ready}, {62'd0, e.lsu, !e.lsu});
                    check_eq("req_addr",  64'(mem_req_addr), 64'(e.addr));
                    check_eq("req_mask",  64'(mem_req_mask), 64'(e.mask));
                    check_eq("req_op",    64'(mem_req_op), 64'(e.op));
                    check_eq("req_wdata", mem_req_wdata, e.wdata);
                    check_eq("req_wen",   64'(mem_req_wen), 64'(e.wen));
                    check_eq("req_memen", 64'(mem_req_memen), 64'd1);
                end
            end
            if (exp_resp.size() == 0) begin
                check_eq("no_resp", {62'd0, lsu_resp_valid, ifu_resp_valid}, 64'd0);
            end else begin
                resp_t r;
                r = exp_resp.pop_front();
                check_eq("resp_who",   {62'd0, lsu_resp_valid, ifu_resp_valid}, {62'd0, r.lsu, !r.lsu});
                check_eq("resp_ifu_d", ifu_resp_rdata, r.data);
                check_eq("resp_lsu_d", lsu_resp_rdata, r.data);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_ifu(input logic [ADDR_W-1:0] addr);
        req_t e;
        e.lsu = 1'b0; e.addr = addr; e.mask = '1; e.op = 3'd3; e.wdata = '0; e.wen = 1'b0;
        exp_req.push_back(e);
        ifu_req_valid = 1'b1;
        ifu_req_addr  = addr;
    endtask

    task automatic push_lsu(input logic [ADDR_W-1:0] addr, input logic [MASK_W-1:0] mask,
                            input logic [2:0] op, input logic [DATA_W-1:0] wdata, input bit wen);
        req_t e;
        e.lsu = 1'b1; e.addr = addr; e.mask = mask; e.op = op; e.wdata = wdata; e.wen = wen;
        exp_req.push_back(e);
        lsu_req_valid = 1'b1;
        lsu_req_addr  = addr;
        lsu_req_mask  = mask;
        lsu_req_op    = op;
        lsu_req_wdata = wdata;
        lsu_req_wen   = wen;
    endtask

    // Waits (bounded) for the given requester to be accepted, then drops its valid in the next cycle.
    task automatic wait_fire(input bit lsu, output int waited);
        bit seen = 1'b0;
        waited = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (mem_req_valid && mem_req_ready && (lsu ? lsu_req_ready : ifu_req_ready)) seen = 1'b1;
            else begin
                waited++;
                step();
            end
        end
        check_eq(lsu ? "fire_lsu" : "fire_ifu", 64'(seen), 64'd1);
        step();
        if (lsu) lsu_req_valid = 1'b0;
        else     ifu_req_valid = 1'b0;
    endtask

    // Called in the first BUSY cycle; memory answers lat cycles after the accepting cycle.
    task automatic respond(input bit lsu, input logic [DATA_W-1:0] data, input int lat);
        resp_t r;
        for (int k = 1; k < lat; k++) begin
            @(negedge clock);
            check_eq("busy_req_valid", 64'(mem_req_valid), 64'd0);
            check_eq("busy_ready", {62'd0, lsu_req_ready, ifu_req_ready}, 64'd0);
            step();
        end
        r.lsu = lsu; r.data = data;
        exp_resp.push_back(r);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = data;
        step();
        mem_resp_valid = 1'b0;
        mem_resp_rdata = {$urandom(), $urandom()};
    endtask

    task automatic both_valid(input bit first_lsu, input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
        int w;
        if (first_lsu) begin
            push_lsu(32'h8000_2000, 8'hFF, 3'd3, 64'd0, 1'b0);
            push_ifu(32'h8000_0040);
        end else begin
            push_ifu(32'h8000_0040);
            push_lsu(32'h8000_2000, 8'hFF, 3'd3, 64'd0, 1'b0);
        end
        wait_fire(first_lsu, w);
        check_eq("both_first_wait", 64'(w), 64'd0);
        respond(first_lsu, d0, 1);
        wait_fire(!first_lsu, w);
        check_eq("both_second_wait", 64'(w), 64'd0);
        respond(!first_lsu, d1, 1);
    endtask

    initial begin
        int w;
        reset = 1'b1;
        ifu_req_valid = 1'b0; ifu_req_addr = '0;
        lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_mask = '0; lsu_req_op = '0;
        lsu_req_wdata = '0; lsu_req_wen = 1'b0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        step(); step();
        reset = 1'b0;

        // Reset state, plus a spurious memory response while idle.
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clock);
        check_eq("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check_eq("rst_ready", {62'd0, lsu_req_ready, ifu_req_ready}, 64'd1);
        check_eq("rst_err", 64'(err_timeout), 64'd0);
        check_eq("idle_spurious_resp", {62'd0, lsu_resp_valid, ifu_resp_valid}, 64'd0);
        step();
        mem_resp_valid = 1'b0;

        // Single IFU fetch, response two cycles after acceptance.
        push_ifu(32'h8000_0000);
        wait_fire(1'b0, w);
        respond(1'b0, 64'h1122_3344_5566_7788, 2);

        // Contention: last grant was IFU, so LSU first in either arbitration mode.
        both_valid(1'b1, 64'hA5A5_0000_0000_0001, 64'h5A5A_0000_0000_0002);

        // LSU store fields pass through unchanged.
        push_lsu(32'h8000_1000, 8'h0F, 3'd3, 64'h0000_0000_DEAD_BEEF, 1'b1);
        wait_fire(1'b1, w);
        respond(1'b1, 64'h0, 3);

        // Contention right after an LSU grant: round-robin picks IFU, fixed priority picks LSU.
        both_valid(!RR, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);

        // Lost response: error pulse in the 4th cycle after acceptance, then a new request is taken.
        push_lsu(32'h8000_3000, 8'hF0, 3'd2, 64'd0, 1'b0);
        wait_fire(1'b1, w);
        for (int c = 1; c <= int'(TIMEOUT); c++) begin
            @(negedge clock);
            check_eq("timeout_pulse", 64'(err_timeout), 64'(c == int'(TIMEOUT)));
            step();
        end
        push_ifu(32'h8000_0100);
        wait_fire(1'b0, w);
        check_eq("after_timeout_wait", 64'(w), 64'd0);
        respond(1'b0, 64'hCAFE_F00D_0000_0005, 1);

        // Response on the last allowed cycle wins over the timeout.
        push_ifu(32'h8000_0200);
        wait_fire(1'b0, w);
        respond(1'b0, 64'h0000_0000_0000_0777, int'(TIMEOUT));

        // Memory back-pressure for three cycles, acceptance on the fourth.
        mem_req_ready = 1'b0;
        push_ifu(32'h8000_0300);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check_eq("stall_ifu_ready", 64'(ifu_req_ready), 64'd0);
            check_eq("stall_req_valid", 64'(mem_req_valid), 64'd1);
            step();
        end
        mem_req_ready = 1'b1;
        wait_fire(1'b0, w);
        check_eq("stall_fire_wait", 64'(w), 64'd0);
        respond(1'b0, 64'h0000_0000_0000_0303, 2);

        // Reset while busy: the late response must not reach any requester.
        push_ifu(32'h8000_0400);
        wait_fire(1'b0, w);
        reset = 1'b1;
        step();
        reset = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'h0000_0000_DEAD_0001;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            check_eq("rst_abort_resp", {62'd0, lsu_resp_valid, ifu_resp_valid}, 64'd0);
            check_eq("rst_abort_ready", 64'(ifu_req_ready), 64'd1);
            step();
        end
        mem_resp_valid = 1'b0;

        step(); step();
        check_eq("req_queue_empty", 64'(exp_req.size()), 64'd0);
        check_eq("resp_queue_empty", 64'(exp_resp.size()), 64'd0);
        check_eq("timeout_count", 64'(err_total), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
